// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU execute unit.
//   alu_op_e      4-bit operation codes issued by the ALU controller
//   exec_state_e  execute-unit FSM states
//   DATA_WIDTH_DEFAULT  default operand/result width
package alu_pkg;

   localparam int DATA_WIDTH_DEFAULT = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_XOR  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_AND  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SLL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001,
      ALU_BEQ  = 4'b1010
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } exec_state_e;

endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: single-cycle ALU datapath and illegal-op decode.
//   op       in   4-bit operation code
//   a, b     in   operands
//   result   out  ADD/SUB/XOR/OR/AND/SLT/SLTU/BEQ result; 0 for shifts and
//                 illegal codes (shifts are produced by the execute unit)
//   illegal  out  op is an unassigned code
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input  logic [3:0]            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  illegal
);

   logic [DATA_WIDTH-1:0] diff;
   logic                  lt_s;
   logic                  lt_u;

   assign diff = a - b;
   assign lt_s = $signed(a) < $signed(b);
   assign lt_u = a < b;

   always_comb begin
      result  = '0;
      illegal = 1'b0;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = diff;
         ALU_XOR:  result = a ^ b;
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
         ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
         ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
         // equality is read from the zero flag of a-b
         ALU_BEQ:  result = diff;
         ALU_SRL, ALU_SLL, ALU_SRA: result = '0;
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle execute unit with valid/ready handshake.
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     request handshake (in_ready high only in IDLE)
//   in_op, in_a, in_b     operation and operands; shift amount in in_b LSBs
//   out_valid/out_ready   result handshake
//   out_result, out_zero, out_illegal  registered result and flags
// Build option ALU_FAST_SHIFT_EN: shifts use a barrel shifter at accept and
// complete in one cycle; otherwise shifts iterate one bit per cycle.
//
// state | meaning
// IDLE  | ready for a request
// SHIFT | iterative shift in progress, counter holds remaining bits
// DONE  | result valid, waiting for out_ready
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
   parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_op,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic                  out_zero,
   output logic                  out_illegal
);

   exec_state_e            state_q;
   alu_op_e                op_q;
   logic [DATA_WIDTH-1:0]  sh_q;
   logic [SHAMT_WIDTH-1:0] cnt_q;

   logic [DATA_WIDTH-1:0]  core_result;
   logic                   core_illegal;
   logic [SHAMT_WIDTH-1:0] shamt;
   logic                   is_shift;
   logic [DATA_WIDTH-1:0]  accept_result;
   logic                   go_iter;
   logic [DATA_WIDTH-1:0]  sh_step;

   alu_comb_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .op      (in_op),
      .a       (in_a),
      .b       (in_b),
      .result  (core_result),
      .illegal (core_illegal)
   );

   assign shamt    = in_b[SHAMT_WIDTH-1:0];
   assign is_shift = (in_op == ALU_SRL) || (in_op == ALU_SLL) || (in_op == ALU_SRA);
   assign in_ready = (state_q == IDLE);

`ifdef ALU_FAST_SHIFT_EN
   always_comb begin
      accept_result = core_result;
      case (in_op)
         ALU_SRL: accept_result = in_a >> shamt;
         ALU_SLL: accept_result = in_a << shamt;
         ALU_SRA: accept_result = DATA_WIDTH'($signed(in_a) >>> shamt);
         default: ;
      endcase
   end
   assign go_iter = 1'b0;
`else
   // a zero-distance shift is just a pass-through of in_a
   assign accept_result = is_shift ? in_a : core_result;
   assign go_iter       = is_shift && (shamt != '0);
`endif

   always_comb begin
      sh_step = sh_q;
      case (op_q)
         ALU_SRL: sh_step = {1'b0, sh_q[DATA_WIDTH-1:1]};
         ALU_SLL: sh_step = {sh_q[DATA_WIDTH-2:0], 1'b0};
         ALU_SRA: sh_step = {sh_q[DATA_WIDTH-1], sh_q[DATA_WIDTH-1:1]};
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= ALU_ADD;
         sh_q        <= '0;
         cnt_q       <= '0;
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_zero    <= 1'b0;
         out_illegal <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (go_iter) begin
                     sh_q    <= in_a;
                     cnt_q   <= shamt;
                     op_q    <= alu_op_e'(in_op);
                     state_q <= SHIFT;
                  end else begin
                     out_result  <= accept_result;
                     out_zero    <= (accept_result == '0);
                     out_illegal <= core_illegal;
                     out_valid   <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            SHIFT: begin
               sh_q  <= sh_step;
               cnt_q <= cnt_q - SHAMT_WIDTH'(1);
               // last bit: publish the shifted value directly so the result
               // is valid n cycles after entering SHIFT
               if (cnt_q == SHAMT_WIDTH'(1)) begin
                  out_result  <= sh_step;
                  out_zero    <= (sh_step == '0);
                  out_illegal <= 1'b0;
                  out_valid   <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against a
// behavioural reference computed with plain operators.
module tb_alu_exec_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_zero;
   logic        out_illegal;

   int checks = 0;
   int errors = 0;

   alu_exec_unit #(
      .DATA_WIDTH  (32),
      .SHAMT_WIDTH (5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_a        (in_a),
      .in_b        (in_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_zero    (out_zero),
      .out_illegal (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a ^ b;
         4'd3:    return a | b;
         4'd4:    return a & b;
         4'd5:    return a >> sh;
         4'd6:    return a << sh;
         4'd7:    return $unsigned($signed(a) >>> sh);
         4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9:    return (a < b) ? 32'd1 : 32'd0;
         4'd10:   return a - b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
      return 1;
`else
      if (op >= 4'd5 && op <= 4'd7) return 1 + int'(b[4:0]);
      return 1;
`endif
   endfunction

   task automatic chk(input string tag, input string what, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s/%s: observed %h expected %h", tag, what, obs, exp);
      end
   endtask

   // Issue one request, measure latency, check result and handshake, retire it.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit rdy_high, input int hold);
      logic [31:0] er;
      int          lat;
      bit          seen;
      bit          busy_ok;
      er = ref_res(op, a, b);
      @(negedge clk);
      chk(tag, "in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      in_op     = op;
      in_a      = a;
      in_b      = b;
      out_ready = rdy_high;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_op    = 4'($urandom);
      in_a     = $urandom;
      in_b     = $urandom;
      lat      = 0;
      seen     = 1'b0;
      busy_ok  = 1'b1;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (out_valid) seen = 1'b1;
         else begin
            if (in_ready) busy_ok = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
         end
      end
      in_valid = 1'b0;
      chk(tag, "out_valid", {31'd0, out_valid}, 32'd1);
      chk(tag, "latency", 32'(lat), 32'(ref_lat(op, b)));
      chk(tag, "in_ready_busy", {31'd0, busy_ok & ~in_ready}, 32'd1);
      chk(tag, "result", out_result, er);
      chk(tag, "zero", {31'd0, out_zero}, {31'd0, er == 32'd0});
      chk(tag, "illegal", {31'd0, out_illegal}, {31'd0, op > 4'd10});
      if (!rdy_high) begin
         for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk(tag, "hold_result", out_result, er);
            chk(tag, "hold_handshake", {30'd0, out_valid, in_ready}, 32'b10);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk(tag, "retired", {30'd0, out_valid, in_ready}, 32'b01);
   endtask

   initial begin
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 4'd0;
      in_a      = 32'd0;
      in_b      = 32'd0;
      out_ready = 1'b0;
      #12;
      chk("reset", "outputs", {28'd0, out_valid, out_zero, out_illegal, in_ready}, 32'b0001);
      chk("reset", "result", out_result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 0);
      run_op("sub_neg", 4'd1, 32'd5, 32'd7, 1'b1, 0);
      run_op("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 1'b1, 0);
      run_op("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 1'b0, 1);
      run_op("beq_eq", 4'd10, 32'h1234, 32'h1234, 1'b1, 0);
      run_op("beq_ne", 4'd10, 32'h1234, 32'h1235, 1'b1, 0);
      run_op("sra4", 4'd7, 32'h8000_0000, 32'h0000_0104, 1'b0, 2);
      run_op("sll0", 4'd6, 32'hDEAD_BEEF, 32'h0000_0020, 1'b1, 0);
      run_op("srl31", 4'd5, 32'h8000_0000, 32'd31, 1'b1, 0);
      run_op("xor_bp", 4'd2, 32'hF0F0, 32'h0FF0, 1'b0, 10);
      run_op("illegal", 4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0);

      // reset in the middle of a long shift
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 4'd7;
      in_a     = 32'h8000_0000;
      in_b     = 32'd20;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_reset", "flags", {28'd0, out_valid, out_zero, out_illegal, in_ready}, 32'b0001);
      chk("mid_reset", "result", out_result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("add_after_reset", 4'd0, 32'd100, 32'd23, 1'b1, 0);

      for (int n = 0; n < 40; n++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
         run_op("random", rop, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
